// File: rtl/conv_1d_pkg.sv
// Shared types and sizing helpers for the 1-D convolution controller
// and its datapath.
package conv_1d_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic int result_w(
    input int img_w,
    input int filt_l,
    input int stride_w
  );
    return (img_w - filt_l) / stride_w + 1;
  endfunction

  // A single-entry space still needs one address bit.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_bram_1d_ctrl_if.sv
// Control bundle between the 1-D conv controller, image BRAM and datapath.
// The stall input exists only when CONV_1D_CTRL_STALL_EN is defined.
interface conv_bram_1d_ctrl_if #(
  parameter int IAW = 5,
  parameter int RAW = 5
) ();

`ifdef CONV_1D_CTRL_STALL_EN
  logic           stall;
`endif
  logic           start;
  logic           last_val;
  logic           busy;
  logic           done;
  logic           img_rden;
  logic [IAW-1:0] img_rdaddr;
  logic           dpath_sr_wren;
  logic           dpath_result_wren;
  logic [RAW-1:0] dpath_result_wraddr;

  modport master (
`ifdef CONV_1D_CTRL_STALL_EN
    input  stall,
`endif
    input  start,
    input  last_val,
    output busy,
    output done,
    output img_rden,
    output img_rdaddr,
    output dpath_sr_wren,
    output dpath_result_wren,
    output dpath_result_wraddr
  );

  modport slave (
`ifdef CONV_1D_CTRL_STALL_EN
    output stall,
`endif
    output start,
    output last_val,
    input  busy,
    input  done,
    input  img_rden,
    input  img_rdaddr,
    input  dpath_sr_wren,
    input  dpath_result_wren,
    input  dpath_result_wraddr
  );

endinterface

// File: rtl/conv_1d_rd_delay.sv
// Valid delay line matching the image BRAM read latency.
// The returned column is shifted into the window LAT cycles after the read.
module conv_1d_rd_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_i,
  output logic valid_o
);

  logic [LAT-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= valid_i;
      for (int i = 1; i < LAT; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign valid_o = sr_q[LAT-1];

endmodule

// File: rtl/conv_bram_1d_ctrl.sv
// 1-D convolution BRAM read / result-strobe controller.
// Optional read stall input enabled by CONV_1D_CTRL_STALL_EN.
module conv_bram_1d_ctrl
  import conv_1d_pkg::*;
#(
  parameter int IMG_W      = 32,
  parameter int FILTER_L   = 3,
  parameter int STRIDE_W   = 1,
  parameter int RAM_RD_LAT = 1,
  localparam int RESULT_W  = result_w(IMG_W, FILTER_L, STRIDE_W),
  localparam int IMG_RAM_ADDR_WIDTH    = addr_w(IMG_W),
  localparam int RESULT_RAM_ADDR_WIDTH = addr_w(RESULT_W)
) (
  input logic clk,
  input logic reset,
  conv_bram_1d_ctrl_if.master bus
);

  localparam int IAW = IMG_RAM_ADDR_WIDTH;
  localparam int RAW = RESULT_RAM_ADDR_WIDTH;
  localparam int CW  = addr_w(IMG_W + 1);
  localparam int SW  = addr_w(STRIDE_W);

  state_e         state_q;
  logic           rden_q;
  logic           busy_q;
  logic           done_q;
  logic [IAW-1:0] addr_q;
  logic           rw_q;
  logic [RAW-1:0] ra_q;
  logic [RAW-1:0] ridx_q;
  logic [CW-1:0]  col_q;
  logic [SW-1:0]  sk_q;
  logic           stall;
  logic           rd_go;
  logic           sr_wren;
  logic           pass_start;

`ifdef CONV_1D_CTRL_STALL_EN
  assign stall = bus.stall;
`else
  assign stall = 1'b0;
`endif

  assign rd_go      = rden_q & ~stall;
  assign pass_start = (state_q == IDLE) & bus.start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rden_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            rden_q  <= 1'b1;
            busy_q  <= 1'b1;
            addr_q  <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (addr_q == IAW'(IMG_W - 1)) begin
              state_q <= DRAIN;
              rden_q  <= 1'b0;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.last_val) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  conv_1d_rd_delay #(
    .LAT(RAM_RD_LAT)
  ) u_rd_delay (
    .clk    (clk),
    .reset  (reset),
    .valid_i(rd_go),
    .valid_o(sr_wren)
  );

  // Once the window is full, a down-counter skips STRIDE_W-1 columns per result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q   <= 1'b0;
      ra_q   <= '0;
      ridx_q <= '0;
      col_q  <= '0;
      sk_q   <= '0;
    end else begin
      rw_q <= 1'b0;
      if (pass_start) begin
        ridx_q <= '0;
        col_q  <= '0;
        sk_q   <= '0;
      end else if (sr_wren) begin
        col_q <= col_q + 1'b1;
        if (col_q >= CW'(FILTER_L - 1)) begin
          if (sk_q == '0) begin
            rw_q   <= 1'b1;
            ra_q   <= ridx_q;
            ridx_q <= ridx_q + 1'b1;
            sk_q   <= SW'(STRIDE_W - 1);
          end else begin
            sk_q <= sk_q - 1'b1;
          end
        end
      end
    end
  end

  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.img_rden            = rd_go;
  assign bus.img_rdaddr          = addr_q;
  assign bus.dpath_sr_wren       = sr_wren;
  assign bus.dpath_result_wren   = rw_q;
  assign bus.dpath_result_wraddr = ra_q;

endmodule

// File: tb/tb_conv_bram_1d_ctrl.sv
// Bench for conv_bram_1d_ctrl: three configurations driven in lockstep,
// stride/latency variants checked alongside the base timing table.
module tb_conv_bram_1d_ctrl;
  import conv_1d_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic last_val;
`ifdef CONV_1D_CTRL_STALL_EN
  logic stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_bram_1d_ctrl_if #(.IAW(addr_w(8)), .RAW(addr_w(result_w(8, 3, 1)))) b0 ();
  conv_bram_1d_ctrl_if #(.IAW(addr_w(8)), .RAW(addr_w(result_w(8, 3, 2)))) b1 ();
  conv_bram_1d_ctrl_if #(.IAW(addr_w(8)), .RAW(addr_w(result_w(8, 3, 1)))) b2 ();

  assign b0.start = start;
  assign b1.start = start;
  assign b2.start = start;
  assign b0.last_val = last_val;
  assign b1.last_val = last_val;
  assign b2.last_val = last_val;
`ifdef CONV_1D_CTRL_STALL_EN
  assign b0.stall = stall;
  assign b1.stall = stall;
  assign b2.stall = stall;
`endif

  conv_bram_1d_ctrl #(
    .IMG_W(8), .FILTER_L(3), .STRIDE_W(1), .RAM_RD_LAT(1)
  ) d0 (.clk(clk), .reset(reset), .bus(b0));

  conv_bram_1d_ctrl #(
    .IMG_W(8), .FILTER_L(3), .STRIDE_W(2), .RAM_RD_LAT(1)
  ) d1 (.clk(clk), .reset(reset), .bus(b1));

  conv_bram_1d_ctrl #(
    .IMG_W(8), .FILTER_L(3), .STRIDE_W(1), .RAM_RD_LAT(3)
  ) d2 (.clk(clk), .reset(reset), .bus(b2));

  typedef struct {
    bit st; bit lv;
    bit rd; int ad; bit sr; bit rw; int ra; bit bz; bit dn;
    bit rw1; int ra1;
    bit sr2; bit rw2; int ra2;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input int cyc, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic all_zero(input int c);
    chk("z_busy", c, int'(b0.busy), 0);
    chk("z_done", c, int'(b0.done) | int'(b1.done) | int'(b2.done), 0);
    chk("z_rden", c, int'(b0.img_rden), 0);
    chk("z_addr", c, int'(b0.img_rdaddr), 0);
    chk("z_sr", c, int'(b0.dpath_sr_wren) | int'(b2.dpath_sr_wren), 0);
    chk("z_rw", c, int'(b0.dpath_result_wren) | int'(b1.dpath_result_wren)
                 | int'(b2.dpath_result_wren), 0);
    chk("z_ra", c, int'(b0.dpath_result_wraddr), 0);
  endtask

  task automatic run_table();
    for (int i = 0; i < 16; i++) begin
      start    = tbl[i].st;
      last_val = tbl[i].lv;
      @(negedge clk);
      chk("rden", i, int'(b0.img_rden), int'(tbl[i].rd));
      chk("addr", i, int'(b0.img_rdaddr), tbl[i].ad);
      chk("sr", i, int'(b0.dpath_sr_wren), int'(tbl[i].sr));
      chk("rw", i, int'(b0.dpath_result_wren), int'(tbl[i].rw));
      chk("ra", i, int'(b0.dpath_result_wraddr), tbl[i].ra);
      chk("busy", i, int'(b0.busy), int'(tbl[i].bz));
      chk("done", i, int'(b0.done), int'(tbl[i].dn));
      chk("s2_rden", i, int'(b1.img_rden), int'(tbl[i].rd));
      chk("s2_rw", i, int'(b1.dpath_result_wren), int'(tbl[i].rw1));
      chk("s2_ra", i, int'(b1.dpath_result_wraddr), tbl[i].ra1);
      chk("s2_done", i, int'(b1.done), int'(tbl[i].dn));
      chk("l3_sr", i, int'(b2.dpath_sr_wren), int'(tbl[i].sr2));
      chk("l3_rw", i, int'(b2.dpath_result_wren), int'(tbl[i].rw2));
      chk("l3_ra", i, int'(b2.dpath_result_wraddr), tbl[i].ra2);
      chk("l3_done", i, int'(b2.done), int'(tbl[i].dn));
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    last_val = 1'b0;
  endtask

  initial begin
    //          st lv rd ad sr rw ra bz dn rw1 ra1 sr2 rw2 ra2
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 3, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 4, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 1, 5, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 6, 1, 1, 2, 1, 0, 1, 1, 1, 1, 0};
    tbl[8]  = '{0, 0, 1, 7, 1, 1, 3, 1, 0, 0, 1, 1, 1, 1};
    tbl[9]  = '{0, 0, 0, 7, 1, 1, 4, 1, 0, 1, 2, 1, 1, 2};
    tbl[10] = '{0, 0, 0, 7, 0, 1, 5, 1, 0, 0, 2, 1, 1, 3};
    tbl[11] = '{1, 0, 0, 7, 0, 0, 5, 1, 0, 0, 2, 1, 1, 4};
    tbl[12] = '{0, 1, 0, 7, 0, 0, 5, 1, 0, 0, 2, 0, 1, 5};
    tbl[13] = '{1, 0, 0, 7, 0, 0, 5, 0, 1, 0, 2, 0, 0, 5};
    tbl[14] = '{0, 0, 0, 7, 0, 0, 5, 0, 0, 0, 2, 0, 0, 5};
    tbl[15] = '{0, 0, 0, 7, 0, 0, 5, 0, 0, 0, 2, 0, 0, 5};

    reset    = 1'b1;
    start    = 1'b1;
    last_val = 1'b1;
`ifdef CONV_1D_CTRL_STALL_EN
    stall = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    all_zero(-1);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    start    = 1'b0;
    last_val = 1'b0;
    @(posedge clk);
    #1;

    run_table();

    // Abort a pass with reset in its fourth RUN cycle.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 5; c <= 12; c++) begin
      @(negedge clk);
      all_zero(c);
      @(posedge clk);
      #1;
    end

    run_table();

`ifdef CONV_1D_CTRL_STALL_EN
    start = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      stall    = (c == 3 || c == 4);
      last_val = (c == 14);
      @(negedge clk);
      if (c >= 1 && c <= 13) begin
        chk("st_rden", c, int'(b0.img_rden),
            int'(c <= 2 || (c >= 5 && c <= 10)));
        if (c <= 2 || (c >= 5 && c <= 10))
          chk("st_addr", c, int'(b0.img_rdaddr), (c <= 2) ? c - 1 : c - 3);
        chk("st_rw", c, int'(b0.dpath_result_wren), int'(c >= 7 && c <= 12));
        if (c >= 7 && c <= 12)
          chk("st_ra", c, int'(b0.dpath_result_wraddr), c - 7);
      end
      if (c == 15) begin
        chk("st_done", c, int'(b0.done), 1);
        chk("st_busy", c, int'(b0.busy), 0);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    stall    = 1'b0;
    last_val = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
